// File: rtl/rle_sched_pkg.sv
// Shared types and widths for the RLE line scheduler: FSM state encoding and the
// 40-bit line record layout delivered to the navigation side.
package rle_sched_pkg;

  localparam int unsigned RUN_W = 10;
  localparam int unsigned ROW_W = 9;
  localparam int unsigned REC_W = 1 + ROW_W + 3 * RUN_W;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StSkip,
    StWaitEnc,
    StPush
  } sched_state_e;

  typedef struct packed {
    logic             frame_first;
    logic [ROW_W-1:0] row;
    logic [RUN_W-1:0] s1;
    logic [RUN_W-1:0] s2;
    logic [RUN_W-1:0] s3;
  } rle_rec_t;

endpackage

// File: rtl/rle_line_scheduler_if.sv
// Pixel-in, encoder-side and record-out signals of the RLE line scheduler.
// slave = scheduler view, master = environment view.
interface rle_line_scheduler_if;
  import rle_sched_pkg::*;

  logic             pix_valid;
  logic             pix_sop;
  logic             pix_bit;
  logic             pix_ready;
  logic             enc_en;
  logic             enc_line_start;
  logic             enc_pixel;
  logic             enc_done;
  logic [RUN_W-1:0] enc_s1;
  logic [RUN_W-1:0] enc_s2;
  logic [RUN_W-1:0] enc_s3;
  logic             out_valid;
  logic             out_ready;
  logic [REC_W-1:0] out_data;
  logic [7:0]       drop_cnt;

  modport slave (
    input  pix_valid, pix_sop, pix_bit, enc_done, enc_s1, enc_s2, enc_s3, out_ready,
    output pix_ready, enc_en, enc_line_start, enc_pixel, out_valid, out_data, drop_cnt
  );

  modport master (
    output pix_valid, pix_sop, pix_bit, enc_done, enc_s1, enc_s2, enc_s3, out_ready,
    input  pix_ready, enc_en, enc_line_start, enc_pixel, out_valid, out_data, drop_cnt
  );

endinterface

// File: rtl/rle_rec_fifo.sv
// Synchronous record FIFO; DEPTH must be a power of two. Simultaneous read and
// write are both honoured, so a write into a full FIFO succeeds when it is also read.
module rle_rec_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rle_line_scheduler.sv
// Column/row sequencer feeding a clock-enabled RLE line encoder and queuing line records.
// Optional RLE_SCHED_MIN_RUN_EN: discard records whose black run is shorter than MIN_RUN.
module rle_line_scheduler
  import rle_sched_pkg::*;
#(
  parameter int unsigned IMAGE_W       = 640,
  parameter int unsigned IMAGE_H       = 480,
  parameter int unsigned ROW_FIRST     = 0,
  parameter int unsigned ROW_LAST      = 479,
  parameter int unsigned ROW_SKIP_LOG2 = 0,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MIN_RUN       = 8
) (
  input logic                 CLK,
  input logic                 RST_N,
  rle_line_scheduler_if.slave bus
);

  localparam int unsigned     ColW     = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam logic [ColW-1:0] LastCol  = ColW'(IMAGE_W - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(IMAGE_H - 1);
  localparam int unsigned     SkipMask = (32'd1 << ROW_SKIP_LOG2) - 32'd1;

  function automatic logic row_sel(input logic [ROW_W-1:0] r);
    int ri;
    ri = int'({23'd0, r});
    return (ri >= int'(ROW_FIRST)) && (ri <= int'(ROW_LAST)) &&
           (((32'(ri) - ROW_FIRST) & SkipMask) == 32'd0);
  endfunction

  sched_state_e     state_q;
  logic [ColW-1:0]  col_q;
  logic [ROW_W-1:0] row_q;
  logic [RUN_W-1:0] s1_q, s2_q, s3_q;
  logic             first_pend_q;
  logic [7:0]       drop_q;

  logic             pix_ready, accept, sop_acc, counting, forward, line_end, row_last;
  logic [ColW-1:0]  cur_col;
  logic [ROW_W-1:0] cur_row, row_inc;
  logic             keep, push_req, fifo_wr, fifo_rd, fifo_full, fifo_empty, drop;
  rle_rec_t         wr_rec;
  logic [REC_W-1:0] head_data;
  logic [$clog2(DEPTH):0] unused_fifo_cnt;

  assign pix_ready = (state_q == StIdle) || (state_q == StFeed) || (state_q == StSkip);
  assign accept    = bus.pix_valid && pix_ready;
  assign sop_acc   = accept && bus.pix_sop;
  // A non-sop pixel in IDLE is discarded without touching the counters.
  assign counting  = accept && (bus.pix_sop || (state_q != StIdle));
  assign cur_col   = bus.pix_sop ? '0 : col_q;
  assign cur_row   = sop_acc ? '0 : row_q;
  assign row_inc   = cur_row + 1'b1;
  assign line_end  = (cur_col == LastCol);
  assign row_last  = (cur_row == LastRow);
  assign forward   = accept && (bus.pix_sop ? row_sel('0) : (state_q == StFeed));

  assign bus.pix_ready      = pix_ready;
  assign bus.enc_en         = forward;
  assign bus.enc_line_start = forward && (cur_col == '0);
  assign bus.enc_pixel      = forward && bus.pix_bit;

`ifdef RLE_SCHED_MIN_RUN_EN
  assign keep = (32'(s2_q) >= MIN_RUN);
`else
  logic unused_min_run;
  assign unused_min_run = ^(32'(MIN_RUN));
  assign keep = 1'b1;
`endif

  assign push_req = (state_q == StPush) && keep;
  assign fifo_rd  = !fifo_empty && bus.out_ready;
  assign fifo_wr  = push_req && (!fifo_full || fifo_rd);
  assign drop     = push_req && fifo_full && !fifo_rd;

  assign wr_rec = '{frame_first: first_pend_q, row: row_q, s1: s1_q, s2: s2_q, s3: s3_q};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      first_pend_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (sop_acc)      first_pend_q <= 1'b1;
      else if (fifo_wr) first_pend_q <= 1'b0;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

      if (counting) begin
        row_q <= cur_row;
        if (line_end) begin
          col_q <= '0;
          if (forward) begin
            state_q <= StWaitEnc;
          end else if (row_last) begin
            state_q <= StIdle;
          end else begin
            row_q   <= row_inc;
            state_q <= row_sel(row_inc) ? StFeed : StSkip;
          end
        end else begin
          col_q   <= cur_col + 1'b1;
          state_q <= forward ? StFeed : StSkip;
        end
      end else begin
        case (state_q)
          StWaitEnc: begin
            if (bus.enc_done) begin
              s1_q    <= bus.enc_s1;
              s2_q    <= bus.enc_s2;
              s3_q    <= bus.enc_s3;
              state_q <= StPush;
            end
          end
          StPush: begin
            if (row_last) begin
              state_q <= StIdle;
            end else begin
              row_q   <= row_inc;
              state_q <= row_sel(row_inc) ? StFeed : StSkip;
            end
          end
          default: ;
        endcase
      end
    end
  end

  rle_rec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_rec),
    .rd_en_i   (fifo_rd),
    .rd_data_o (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (unused_fifo_cnt)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_data;
  assign bus.drop_cnt  = drop_q;

endmodule
